// File: rtl/serial_add_unit.sv
// Bit-serial adder/subtractor: streams two operands LSB-first through a single
// full adder, feeding the carry back through a flop, one bit per clock.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum_c,
  output logic co_c
);

  assign sum_c = a ^ b ^ ci;
  assign co_c  = (a & b) | (ci & (a ^ b));

endmodule

module serial_add_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  OP_SUB,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  CO,
  output logic                  OVF
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] a_sr, a_sr_nxt;
  logic [DATA_WIDTH-1:0] b_sr, b_sr_nxt;
  logic [DATA_WIDTH-1:0] y_sr, y_sr_nxt;
  logic                  carry, carry_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  busy_nxt, done_nxt, co_nxt, ovf_nxt;
  logic [DATA_WIDTH-1:0] y_nxt;

  logic fa_sum_c;
  logic fa_co_c;
  logic last_bit_c;

  full_adder u_full_adder (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .ci    (carry),
    .sum_c (fa_sum_c),
    .co_c  (fa_co_c)
  );

  assign last_bit_c = (cnt == CNT_W'(DATA_WIDTH - 1));

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      y_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      Y     <= '0;
      CO    <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      state <= state_nxt;
      a_sr  <= a_sr_nxt;
      b_sr  <= b_sr_nxt;
      y_sr  <= y_sr_nxt;
      carry <= carry_nxt;
      cnt   <= cnt_nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
      Y     <= y_nxt;
      CO    <= co_nxt;
      OVF   <= ovf_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    a_sr_nxt  = a_sr;
    b_sr_nxt  = b_sr;
    y_sr_nxt  = y_sr;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    y_nxt     = Y;
    co_nxt    = CO;
    ovf_nxt   = OVF;

    case (state)
      IDLE, FINISH: begin
        state_nxt = IDLE;
        if (START) begin
          // Subtraction is A + ~B + 1, the +1 entering as the initial carry
          a_sr_nxt  = A;
          b_sr_nxt  = OP_SUB ? ~B : B;
          carry_nxt = OP_SUB;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        a_sr_nxt  = {1'b0, a_sr[DATA_WIDTH-1:1]};
        b_sr_nxt  = {1'b0, b_sr[DATA_WIDTH-1:1]};
        y_sr_nxt  = {fa_sum_c, y_sr[DATA_WIDTH-1:1]};
        carry_nxt = fa_co_c;
        cnt_nxt   = cnt + CNT_W'(1);
        busy_nxt  = 1'b1;
        if (last_bit_c) begin
          // Carry into the MSB differs from carry out => signed overflow
          y_nxt     = {fa_sum_c, y_sr[DATA_WIDTH-1:1]};
          co_nxt    = fa_co_c;
          ovf_nxt   = carry ^ fa_co_c;
          cnt_nxt   = cnt;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = FINISH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed self-checking bench for serial_add_unit: vector table plus
// hand-written sequences for ignored START, FINISH-cycle START and async reset.

module tb_serial_add_unit;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         OP_SUB;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] Y;
  logic         CO;
  logic         OVF;

  int total = 0;
  int bad   = 0;

  serial_add_unit #(.DATA_WIDTH(W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .OP_SUB (OP_SUB),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .Y      (Y),
    .CO     (CO),
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request at the next falling edge; edge k is the following rising edge
  task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    START  = 1'b1;
    OP_SUB = op;
    A      = a;
    B      = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("busy_after_start", 64'(BUSY), 64'd1);
    check("done_after_start", 64'(DONE), 64'd0);
  endtask

  // Wait for DONE; check latency, busy length, held output and result
  task automatic wait_done(input logic [W-1:0] exp_y, input logic exp_co, input logic exp_ovf,
                           input logic [W-1:0] prev_y, input int intrude_at);
    int  n      = 0;
    int  busy_n = 1;
    bit  got    = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge CLK);
      #1;
      n++;
      START = 1'b0;
      if (DONE) begin
        got = 1;
      end else begin
        if (BUSY) busy_n++;
        if (n == 10) check("y_held_during_run", 64'(Y), 64'(prev_y));
        if (n == intrude_at) begin
          START  = 1'b1;
          OP_SUB = 1'b0;
          A      = 32'd9;
          B      = 32'd9;
        end
      end
    end
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(n), 64'd32);
    check("busy_cycles", 64'(busy_n), 64'd32);
    check("busy_at_done", 64'(BUSY), 64'd0);
    check("y", 64'(Y), 64'(exp_y));
    check("co", 64'(CO), 64'(exp_co));
    check("ovf", 64'(OVF), 64'(exp_ovf));
  endtask

  task automatic check_done_falls();
    @(posedge CLK);
    #1;
    check("done_pulse_width", 64'(DONE), 64'd0);
    check("idle_busy", 64'(BUSY), 64'd0);
  endtask

  initial begin
    logic [W-1:0] prev;

    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};

    RST    = 1'b1;
    START  = 1'b0;
    OP_SUB = 1'b0;
    A      = '0;
    B      = '0;
    #2;
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    check("reset_y", 64'(Y), 64'd0);
    check("reset_co", 64'(CO), 64'd0);
    check("reset_ovf", 64'(OVF), 64'd0);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;

    prev = '0;
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].op_sub, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].y, vecs[i].co, vecs[i].ovf, prev, 0);
      check_done_falls();
      prev = vecs[i].y;
    end

    // START during RUN is ignored
    start_op(1'b0, 32'd2, 32'd2);
    wait_done(32'd4, 1'b0, 1'b0, prev, 10);
    // START in the FINISH cycle is accepted immediately
    start_op(1'b0, 32'd3, 32'd4);
    wait_done(32'd7, 1'b0, 1'b0, 32'd4, 0);
    check_done_falls();

    // Asynchronous reset mid-run, between clock edges
    start_op(1'b0, 32'hAAAA_0000, 32'h0000_5555);
    repeat (10) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("async_rst_busy", 64'(BUSY), 64'd0);
    check("async_rst_done", 64'(DONE), 64'd0);
    check("async_rst_y", 64'(Y), 64'd0);
    check("async_rst_co", 64'(CO), 64'd0);
    check("async_rst_ovf", 64'(OVF), 64'd0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    start_op(1'b0, 32'd1, 32'd1);
    wait_done(32'd2, 1'b0, 1'b0, 32'd0, 0);
    check_done_falls();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
